peg_solitaire_engine: RTL

PEG_SOLITAIRE_ENGINE -- requirements
Module: peg_solitaire_engine

---
 rtl/peg_solitaire_engine_pkg.sv | 59 +++++
 rtl/peg_solitaire_engine_undo_stack.sv | 54 +++++
 rtl/peg_solitaire_engine.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/peg_solitaire_engine_pkg.sv
// Shared definitions for the peg solitaire engine.
//   op_e     : request opcode (MOVE / UNDO)
//   dir_e    : jump direction (LEFT, RIGHT, UP = y-1, DOWN = y+1)
//   status_e : response status codes
//   state_e  : engine FSM states
//   cell_exists / dir_dx / dir_dy : board geometry helpers
package peg_solitaire_engine_pkg;

    typedef enum logic {
        OP_MOVE = 1'b0,
        OP_UNDO = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_OK         = 2'd0,
        ST_ILLEGAL    = 2'd1,
        ST_UNDO_OK    = 2'd2,
        ST_UNDO_EMPTY = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_SCAN = 2'd2
    } state_e;

    // A cell is missing only when both coordinates fall inside a corner band.
    function automatic logic cell_exists(input int x, input int y, input int bw, input int corner);
        logic x_dead;
        logic y_dead;
        x_dead = (x < corner) || (x >= bw - corner);
        y_dead = (y < corner) || (y >= bw - corner);
        return !(x_dead && y_dead);
    endfunction

    function automatic int dir_dx(input logic [1:0] d);
        case (d)
            DIR_LEFT:  return -1;
            DIR_RIGHT: return 1;
            default:   return 0;
        endcase
    endfunction

    function automatic int dir_dy(input logic [1:0] d);
        case (d)
            DIR_UP:   return -1;
            DIR_DOWN: return 1;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/peg_solitaire_engine_undo_stack.sv
// Circular undo history for the peg solitaire engine.
//   clk, rst_n : clock and asynchronous active-low reset
//   push       : store push_data as the newest entry (overwrites the oldest when full)
//   pop        : discard the newest entry (ignored when empty)
//   push_data  : entry to store
//   top_data   : newest entry (combinational read)
//   empty/full : occupancy flags
module peg_undo_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      count_reg;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    // DEPTH is a power of two, so the pointer wraps naturally.
    assign top_data = mem[wr_ptr_reg - AW'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (!full) begin
                count_reg <= count_reg + (AW+1)'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr_reg <= wr_ptr_reg - AW'(1);
            count_reg  <= count_reg - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/peg_solitaire_engine.sv
// Peg solitaire move engine: validates and applies MOVE/UNDO requests on a
// cross-shaped board, then scans every cell to decide whether any legal move
// remains.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_op               : 0 = MOVE, 1 = UNDO
//   piece_x/piece_y      : moving peg column/row
//   direction            : LEFT, RIGHT, UP (y-1), DOWN (y+1)
//   resp_valid/status    : one-cycle response pulse with OK/ILLEGAL/UNDO_OK/UNDO_EMPTY
//   piece_count          : pegs currently on the board
//   game_over            : no legal move exists (valid while req_ready)
//   board                : occupancy, bit y*BOARD_W+x
module peg_solitaire_engine
    import peg_solitaire_engine_pkg::*;
#(
    parameter int BOARD_W    = 7,
    parameter int CORNER     = 2,
    parameter int UNDO_DEPTH = 8,
    localparam int CW = $clog2(BOARD_W),
    localparam int NW = $clog2(BOARD_W*BOARD_W+1),
    localparam int NC = BOARD_W*BOARD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_op,
    input  logic [CW-1:0] piece_x,
    input  logic [CW-1:0] piece_y,
    input  logic [1:0]    direction,
    output logic          resp_valid,
    output logic [1:0]    resp_status,
    output logic [NW-1:0] piece_count,
    output logic          game_over,
    output logic [NC-1:0] board
);

    localparam int IW = $clog2(NC);
    localparam int EW = 2*CW + 2;

    function automatic logic [NC-1:0] reset_image();
        logic [NC-1:0] img;
        img = '0;
        for (int y = 0; y < BOARD_W; y++) begin
            for (int x = 0; x < BOARD_W; x++) begin
                img[y*BOARD_W+x] = cell_exists(x, y, BOARD_W, CORNER) &&
                                   !((x == BOARD_W/2) && (y == BOARD_W/2));
            end
        end
        return img;
    endfunction

    function automatic int count_cells();
        int n;
        n = 0;
        for (int y = 0; y < BOARD_W; y++) begin
            for (int x = 0; x < BOARD_W; x++) begin
                if (cell_exists(x, y, BOARD_W, CORNER)) begin
                    n++;
                end
            end
        end
        return n;
    endfunction

    localparam logic [NC-1:0] RESET_BOARD = reset_image();
    localparam logic [NW-1:0] RESET_COUNT = NW'(count_cells() - 1);

    // Origin, jumped and destination cells must all be on the board; the jumped
    // cell is in range whenever both ends are.
    function automatic logic move_legal(input logic [NC-1:0] b, input int x, input int y,
                                        input logic [1:0] d);
        int mx;
        int my;
        int tx;
        int ty;
        logic ok;
        mx = x + dir_dx(d);
        my = y + dir_dy(d);
        tx = x + 2*dir_dx(d);
        ty = y + 2*dir_dy(d);
        ok = 1'b0;
        if ((x >= 0) && (x < BOARD_W) && (y >= 0) && (y < BOARD_W) &&
            (tx >= 0) && (tx < BOARD_W) && (ty >= 0) && (ty < BOARD_W)) begin
            if (cell_exists(x, y, BOARD_W, CORNER) && cell_exists(mx, my, BOARD_W, CORNER) &&
                cell_exists(tx, ty, BOARD_W, CORNER)) begin
                ok = b[IW'(y*BOARD_W+x)] && b[IW'(my*BOARD_W+mx)] && !b[IW'(ty*BOARD_W+tx)];
            end
        end
        return ok;
    endfunction

    state_e        state_reg, state_next;
    logic [NC-1:0] board_reg, board_next;
    logic [NW-1:0] count_reg, count_next;
    logic          resp_valid_reg, resp_valid_next;
    status_e       resp_status_reg, resp_status_next;
    logic          game_over_reg, game_over_next;
    logic [CW-1:0] scan_x_reg, scan_x_next;
    logic [CW-1:0] scan_y_reg, scan_y_next;
    logic          found_reg, found_next;
    op_e           op_reg, op_next;
    logic [CW-1:0] x_reg, x_next;
    logic [CW-1:0] y_reg, y_next;
    logic [1:0]    dir_reg, dir_next;

    logic          stack_push;
    logic          stack_pop;
    logic [EW-1:0] stack_top;
    logic          stack_empty;
    // The history overwrites its oldest entry when full, so this flag is not consulted.
    logic          stack_full_unused;
    logic [CW-1:0] top_x;
    logic [CW-1:0] top_y;
    logic [1:0]    top_dir;

    logic [CW-1:0] eff_x;
    logic [CW-1:0] eff_y;
    logic [1:0]    eff_dir;
    int            eff_off;
    logic [IW-1:0] org_idx;
    logic [IW-1:0] mid_idx;
    logic [IW-1:0] dst_idx;
    logic          exec_legal;
    logic [3:0]    scan_legal;
    logic          scan_last;

    peg_undo_stack #(
        .DEPTH (UNDO_DEPTH),
        .WIDTH (EW)
    ) u_undo_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data ({x_reg, y_reg, dir_reg}),
        .top_data  (stack_top),
        .empty     (stack_empty),
        .full      (stack_full_unused)
    );

    assign {top_x, top_y, top_dir} = stack_top;

    // A MOVE acts on the registered request; an UNDO replays the newest history entry.
    assign eff_x      = (op_reg == OP_UNDO) ? top_x   : x_reg;
    assign eff_y      = (op_reg == OP_UNDO) ? top_y   : y_reg;
    assign eff_dir    = (op_reg == OP_UNDO) ? top_dir : dir_reg;
    assign eff_off    = dir_dx(eff_dir) + dir_dy(eff_dir)*BOARD_W;
    assign org_idx    = IW'(int'(eff_y)*BOARD_W + int'(eff_x));
    assign mid_idx    = IW'(int'(eff_y)*BOARD_W + int'(eff_x) + eff_off);
    assign dst_idx    = IW'(int'(eff_y)*BOARD_W + int'(eff_x) + 2*eff_off);
    assign exec_legal = move_legal(board_reg, int'(x_reg), int'(y_reg), dir_reg);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_scan_dir
            assign scan_legal[gi] = move_legal(board_reg, int'(scan_x_reg), int'(scan_y_reg), 2'(gi));
        end
    endgenerate

    assign scan_last = (scan_x_reg == CW'(BOARD_W-1)) && (scan_y_reg == CW'(BOARD_W-1));

    always_comb begin
        state_next       = state_reg;
        board_next       = board_reg;
        count_next       = count_reg;
        resp_valid_next  = 1'b0;
        resp_status_next = resp_status_reg;
        game_over_next   = game_over_reg;
        scan_x_next      = scan_x_reg;
        scan_y_next      = scan_y_reg;
        found_next       = found_reg;
        op_next          = op_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        dir_next         = dir_reg;
        stack_push       = 1'b0;
        stack_pop        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = S_EXEC;
                    op_next    = op_e'(req_op);
                    x_next     = piece_x;
                    y_next     = piece_y;
                    dir_next   = direction;
                end
            end
            S_EXEC: begin
                state_next      = S_SCAN;
                scan_x_next     = '0;
                scan_y_next     = '0;
                found_next      = 1'b0;
                resp_valid_next = 1'b1;
                if (op_reg == OP_MOVE) begin
                    if (exec_legal) begin
                        board_next[org_idx] = 1'b0;
                        board_next[mid_idx] = 1'b0;
                        board_next[dst_idx] = 1'b1;
                        count_next          = count_reg - NW'(1);
                        stack_push          = 1'b1;
                        resp_status_next    = ST_OK;
                    end else begin
                        resp_status_next = ST_ILLEGAL;
                    end
                end else if (!stack_empty) begin
                    board_next[org_idx] = 1'b1;
                    board_next[mid_idx] = 1'b1;
                    board_next[dst_idx] = 1'b0;
                    count_next          = count_reg + NW'(1);
                    stack_pop           = 1'b1;
                    resp_status_next    = ST_UNDO_OK;
                end else begin
                    resp_status_next = ST_UNDO_EMPTY;
                end
            end
            S_SCAN: begin
                found_next = found_reg | (|scan_legal);
                if (scan_last) begin
                    game_over_next = !(found_reg || (|scan_legal));
                    state_next     = S_IDLE;
                end else if (scan_x_reg == CW'(BOARD_W-1)) begin
                    scan_x_next = '0;
                    scan_y_next = scan_y_reg + CW'(1);
                end else begin
                    scan_x_next = scan_x_reg + CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_SCAN;
            board_reg       <= RESET_BOARD;
            count_reg       <= RESET_COUNT;
            resp_valid_reg  <= 1'b0;
            resp_status_reg <= ST_OK;
            game_over_reg   <= 1'b0;
            scan_x_reg      <= '0;
            scan_y_reg      <= '0;
            found_reg       <= 1'b0;
            op_reg          <= OP_MOVE;
            x_reg           <= '0;
            y_reg           <= '0;
            dir_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            board_reg       <= board_next;
            count_reg       <= count_next;
            resp_valid_reg  <= resp_valid_next;
            resp_status_reg <= resp_status_next;
            game_over_reg   <= game_over_next;
            scan_x_reg      <= scan_x_next;
            scan_y_reg      <= scan_y_next;
            found_reg       <= found_next;
            op_reg          <= op_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            dir_reg         <= dir_next;
        end
    end

    assign req_ready   = (state_reg == S_IDLE);
    assign resp_valid  = resp_valid_reg;
    assign resp_status = resp_status_reg;
    assign piece_count = count_reg;
    assign game_over   = game_over_reg;
    assign board       = board_reg;

endmodule
